// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor
// Receive-side checker for the VGA timing produced by the pong display path.
// Consumes the active-low HS/VS pair, qualified by the pixel strobe. It
// recovers the active pixel position, measures line and frame lengths, flags
// timing errors and reports lock once the timing has been stable for
// LOCK_FRAMES frames.
//
// Ports
//   i_clk          system clock
//   i_rst          synchronous reset, active-high
//   i_pix_stb      pixel strobe, one i_clk wide; all sampling is qualified by it
//   i_hs, i_vs     horizontal / vertical sync, active-low
//   o_x, o_y       recovered active pixel position, 0 outside the active area
//   o_active       recovered pixel lies inside the active area
//   o_line_len     strobes between the last two HS falls
//   o_frame_lines  HS falls between the last two VS falls
//   o_err_h        one-clock pulse: bad line length or bad HS width
//   o_err_v        one-clock pulse: bad frame length or bad VS width
//   o_frame_stb    one-clock pulse on every VS fall
//   o_locked       timing stable for LOCK_FRAMES frames
module vga_sync_monitor #(
  parameter logic [9:0] H_TOTAL     = 10'd800,
  parameter logic [9:0] H_SYNC      = 10'd96,
  parameter logic [9:0] H_ACT_START = 10'd144,
  parameter logic [9:0] H_ACTIVE    = 10'd640,
  parameter logic [9:0] V_TOTAL     = 10'd525,
  parameter logic [9:0] V_SYNC      = 10'd2,
  parameter logic [9:0] V_ACT_START = 10'd34,
  parameter logic [9:0] V_ACTIVE    = 10'd480,
  parameter logic [3:0] LOCK_FRAMES = 4'd2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pix_stb,
  input  logic       i_hs,
  input  logic       i_vs,
  output logic [9:0] o_x,
  output logic [8:0] o_y,
  output logic       o_active,
  output logic [9:0] o_line_len,
  output logic [9:0] o_frame_lines,
  output logic       o_err_h,
  output logic       o_err_v,
  output logic       o_frame_stb,
  output logic       o_locked
);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [9:0] H_ACT_END = H_ACT_START + H_ACTIVE - 10'd1;
  localparam logic [9:0] V_ACT_END = V_ACT_START + V_ACTIVE - 10'd1;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == 10'd1023) ? v : v + 10'd1;
  endfunction

  logic [9:0] h_cnt_r;
  logic [9:0] v_cnt_r;
  logic       hs_prev_r;
  logic       vs_prev_r;
  logic       v_pend_r;
  logic       h_seen_r;
  state_t     state_r;
  state_t     state_nx_s;
  logic [3:0] clean_r;
  logic [3:0] clean_nx_s;

  logic       hs_fall_s;
  logic       hs_rise_s;
  logic       vs_fall_s;
  logic       vs_rise_s;
  logic [9:0] h_pos_s;
  logic [9:0] v_pos_s;
  logic [9:0] h_len_s;
  logic [9:0] v_len_s;
  logic       v_pend_nx_s;
  logic       err_h_s;
  logic       err_v_s;
  logic       locked_nx_s;
  logic       active_s;
  logic [9:0] x_s;
  logic [8:0] y_s;

  // Sync edge detection against the levels seen on the previous strobe
  always_comb begin
    hs_fall_s = i_pix_stb &  hs_prev_r & ~i_hs;
    hs_rise_s = i_pix_stb & ~hs_prev_r &  i_hs;
    vs_fall_s = i_pix_stb &  vs_prev_r & ~i_vs;
    vs_rise_s = i_pix_stb & ~vs_prev_r &  i_vs;
  end

  // Position of this strobe in the line/frame, and the timing checks
  always_comb begin
    h_len_s = h_cnt_r + 10'd1;
    v_len_s = v_cnt_r + 10'd1;
    if (hs_fall_s) begin
      h_pos_s = 10'd0;
    end else begin
      h_pos_s = sat_inc(h_cnt_r);
    end
    // A VS fall stays pending until the next HS fall restarts the line count;
    // an HS fall on the same strobe consumes it immediately.
    v_pend_nx_s = v_pend_r | vs_fall_s;
    v_pos_s     = v_cnt_r;
    if (hs_fall_s) begin
      if (v_pend_nx_s) begin
        v_pos_s = 10'd0;
      end else begin
        v_pos_s = sat_inc(v_cnt_r);
      end
      v_pend_nx_s = 1'b0;
    end else begin
      v_pos_s = v_cnt_r;
    end
    // The first interval after reset is never measured (h_seen / SEARCH)
    err_h_s = h_seen_r & ((hs_fall_s & (h_len_s != H_TOTAL)) |
                          (hs_rise_s & (h_pos_s != H_SYNC)));
    err_v_s = (state_r != ST_SEARCH) &
              ((vs_fall_s & (v_len_s != V_TOTAL)) |
               (vs_rise_s & (v_pend_r | (v_len_s != V_SYNC))));
  end

  // Lock FSM next state; an error outranks a VS fall on the same strobe
  always_comb begin
    state_nx_s = state_r;
    clean_nx_s = clean_r;
    case (state_r)
      ST_SEARCH: begin
        if (vs_fall_s) begin
          state_nx_s = ST_TRACK;
          clean_nx_s = 4'd0;
        end else begin
          state_nx_s = ST_SEARCH;
        end
      end
      ST_TRACK: begin
        if (err_h_s | err_v_s) begin
          clean_nx_s = 4'd0;
        end else if (vs_fall_s) begin
          clean_nx_s = clean_r + 4'd1;
          if ((clean_r + 4'd1) == LOCK_FRAMES) begin
            state_nx_s = ST_LOCKED;
          end else begin
            state_nx_s = ST_TRACK;
          end
        end else begin
          state_nx_s = ST_TRACK;
        end
      end
      ST_LOCKED: begin
        if (err_h_s | err_v_s) begin
          state_nx_s = ST_TRACK;
          clean_nx_s = 4'd0;
        end else begin
          state_nx_s = ST_LOCKED;
        end
      end
      default: begin
        state_nx_s = ST_SEARCH;
        clean_nx_s = 4'd0;
      end
    endcase
  end

  // FSM outputs and active-area recovery for this strobe
  always_comb begin
    locked_nx_s = (state_nx_s == ST_LOCKED);
    if ((state_r != ST_SEARCH) && !v_pend_nx_s &&
        (h_pos_s >= H_ACT_START) && (h_pos_s <= H_ACT_END) &&
        (v_pos_s >= V_ACT_START) && (v_pos_s <= V_ACT_END)) begin
      active_s = 1'b1;
      x_s      = h_pos_s - H_ACT_START;
      y_s      = v_pos_s[8:0] - V_ACT_START[8:0];
    end else begin
      active_s = 1'b0;
      x_s      = 10'd0;
      y_s      = 9'd0;
    end
  end

  // Lock FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= ST_SEARCH;
      clean_r <= 4'd0;
    end else begin
      state_r <= state_nx_s;
      clean_r <= clean_nx_s;
    end
  end

  // Sync history and position counters, advanced only on strobes
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h_cnt_r   <= 10'd0;
      v_cnt_r   <= 10'd0;
      hs_prev_r <= 1'b1;
      vs_prev_r <= 1'b1;
      v_pend_r  <= 1'b0;
      h_seen_r  <= 1'b0;
    end else if (i_pix_stb) begin
      hs_prev_r <= i_hs;
      vs_prev_r <= i_vs;
      h_cnt_r   <= h_pos_s;
      v_cnt_r   <= v_pos_s;
      v_pend_r  <= v_pend_nx_s;
      if (hs_fall_s) begin
        h_seen_r <= 1'b1;
      end
    end
  end

  // Registered outputs; pulses clear on every clock, the rest hold between strobes
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_x           <= 10'd0;
      o_y           <= 9'd0;
      o_active      <= 1'b0;
      o_line_len    <= 10'd0;
      o_frame_lines <= 10'd0;
      o_err_h       <= 1'b0;
      o_err_v       <= 1'b0;
      o_frame_stb   <= 1'b0;
      o_locked      <= 1'b0;
    end else begin
      o_err_h     <= err_h_s;
      o_err_v     <= err_v_s;
      o_frame_stb <= vs_fall_s;
      o_locked    <= locked_nx_s;
      if (i_pix_stb) begin
        o_x      <= x_s;
        o_y      <= y_s;
        o_active <= active_s;
        if (hs_fall_s && h_seen_r) begin
          o_line_len <= h_len_s;
        end
        if (vs_fall_s) begin
          o_frame_lines <= v_len_s;
        end
      end
    end
  end

endmodule
